// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and widths for the 3-bit counter checker
package counter_pkg;

    localparam int COUNT_W = 3;
    localparam int ERR_W   = 4;
    localparam int WRAP_W  = 8;
    localparam int RUN_W   = 4;

    localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/count_step.sv
// rtl/count_step.sv - next expected counter value from the previous value and direction
//   last     : previous counter value
//   dir      : 0 = count up, 1 = count down
//   expected : last +/- 1, wrapping modulo 2**COUNT_W
module count_step
    import counter_pkg::*;
(
    input  logic [COUNT_W-1:0] last,
    input  logic               dir,
    output logic [COUNT_W-1:0] expected
);

    assign expected = dir ? (last - 3'd1) : (last + 3'd1);

endmodule

// File: rtl/counter_checker_3bit.sv
// rtl/counter_checker_3bit.sv - locks onto a 3-bit up/down counter stream and counts step errors
//   clk, rst      : clock, asynchronous active-high reset
//   sample        : count/dir valid this cycle
//   count, dir    : observed value and expected direction (0 up, 1 down)
//   clear         : synchronous clear of lock and statistics, wins over sample
//   locked        : checker is in LOCKED
//   error         : one-cycle pulse per mismatch counted in LOCKED
//   sticky_err    : any counted error since clear/reset
//   err_cnt       : counted errors, saturating
//   wrap_cnt      : matched wrap-arounds in LOCKED, modulo 256
//   last          : most recent sampled count
module counter_checker_3bit
    import counter_pkg::*;
#(
    parameter int LOCK_LEN    = 2,
    parameter int RELOCK_ERRS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample,
    input  logic [COUNT_W-1:0] count,
    input  logic               dir,
    input  logic               clear,
    output logic               locked,
    output logic               error,
    output logic               sticky_err,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [WRAP_W-1:0]  wrap_cnt,
    output logic [COUNT_W-1:0] last
);

    localparam logic [RUN_W-1:0] LOCK_LEN_V    = LOCK_LEN[RUN_W-1:0];
    localparam logic [RUN_W-1:0] RELOCK_ERRS_V = RELOCK_ERRS[RUN_W-1:0];

    chk_state_t         state;
    logic [RUN_W-1:0]   run;
    logic [RUN_W-1:0]   miss;
    logic [COUNT_W-1:0] expected;
    logic               match;
    logic               wrap_hit;

    count_step u_step (
        .last     (last),
        .dir      (dir),
        .expected (expected)
    );

    assign match = (count == expected);

    // A matched step across the 7/0 boundary in the direction being checked
    assign wrap_hit = (!dir && last == 3'd7) || (dir && last == 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            run        <= '0;
            miss       <= '0;
            locked     <= 1'b0;
            error      <= 1'b0;
            sticky_err <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
            last       <= '0;
        end else if (clear) begin
            state      <= ST_IDLE;
            run        <= '0;
            miss       <= '0;
            locked     <= 1'b0;
            error      <= 1'b0;
            sticky_err <= 1'b0;
            err_cnt    <= '0;
            wrap_cnt   <= '0;
            last       <= '0;
        end else begin
            error <= 1'b0;
            if (sample) begin
                last <= count;
                case (state)
                    ST_IDLE: begin
                        state <= ST_SYNC;
                        run   <= '0;
                    end
                    ST_SYNC: begin
                        if (match) begin
                            if (run + 4'd1 == LOCK_LEN_V) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                                miss   <= '0;
                            end else begin
                                run <= run + 4'd1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (match) begin
                            miss <= '0;
                            if (wrap_hit)
                                wrap_cnt <= wrap_cnt + 8'd1;
                        end else begin
                            error      <= 1'b1;
                            sticky_err <= 1'b1;
                            if (err_cnt != ERR_MAX)
                                err_cnt <= err_cnt + 4'd1;
                            if (miss + 4'd1 == RELOCK_ERRS_V) begin
                                state  <= ST_SYNC;
                                locked <= 1'b0;
                                run    <= '0;
                                miss   <= '0;
                            end else begin
                                miss <= miss + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_checker_3bit.sv
// tb/tb_counter_checker_3bit.sv - scoreboard bench for counter_checker_3bit
module tb_counter_checker_3bit;

    typedef struct packed {
        logic       locked;
        logic       error;
        logic       sticky;
        logic [3:0] err_cnt;
        logic [7:0] wrap;
        logic [2:0] last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample = 1'b0;
    logic [2:0] count = '0;
    logic       dir = 1'b0;
    logic       clear = 1'b0;
    logic       locked, error, sticky_err;
    logic [3:0] err_cnt;
    logic [7:0] wrap_cnt;
    logic [2:0] last;

    logic       sample2 = 1'b0;
    logic [2:0] count2 = '0;
    logic       dir2 = 1'b0;
    logic       locked2, error2, sticky2;
    logic [3:0] err_cnt2;
    logic [7:0] wrap_cnt2;
    logic [2:0] last2;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    counter_checker_3bit dut (
        .clk(clk), .rst(rst), .sample(sample), .count(count), .dir(dir), .clear(clear),
        .locked(locked), .error(error), .sticky_err(sticky_err),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .last(last)
    );

    counter_checker_3bit #(.LOCK_LEN(1), .RELOCK_ERRS(15)) dut2 (
        .clk(clk), .rst(rst), .sample(sample2), .count(count2), .dir(dir2), .clear(1'b0),
        .locked(locked2), .error(error2), .sticky_err(sticky2),
        .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2), .last(last2)
    );

    function automatic exp_t mk(input logic l, input logic e, input logic s,
                                input logic [3:0] ec, input logic [7:0] w, input logic [2:0] la);
        exp_t r;
        r.locked = l; r.error = e; r.sticky = s; r.err_cnt = ec; r.wrap = w; r.last = la;
        return r;
    endfunction

    function automatic exp_t act();
        return mk(locked, error, sticky_err, err_cnt, wrap_cnt, last);
    endfunction

    task automatic check(input string name, input exp_t a, input exp_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got lk=%0b er=%0b st=%0b ec=%0d wr=%0d la=%0d want lk=%0b er=%0b st=%0b ec=%0d wr=%0d la=%0d",
                     name, a.locked, a.error, a.sticky, a.err_cnt, a.wrap, a.last,
                     e.locked, e.error, e.sticky, e.err_cnt, e.wrap, e.last);
        end
    endtask

    // One clock of stimulus; expected post-edge outputs go to the scoreboard
    task automatic step(input logic s, input logic [2:0] c, input logic d, input logic clr, input exp_t e);
        @(negedge clk);
        sample = s; count = c; dir = d; clear = clr;
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("scoreboard", act(), e);
        end
    end

    initial begin
        logic [2:0] cur;

        #2;
        check("reset_state", act(), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // lock going up, then wrap 7->0
        step(1, 3'd3, 0, 0, mk(0, 0, 0, 0, 0, 3));
        step(1, 3'd4, 0, 0, mk(0, 0, 0, 0, 0, 4));
        step(1, 3'd5, 0, 0, mk(1, 0, 0, 0, 0, 5));
        step(0, 3'd2, 1, 0, mk(1, 0, 0, 0, 0, 5));
        step(1, 3'd6, 0, 0, mk(1, 0, 0, 0, 0, 6));
        step(1, 3'd7, 0, 0, mk(1, 0, 0, 0, 0, 7));
        step(1, 3'd0, 0, 0, mk(1, 0, 0, 0, 1, 0));
        step(1, 3'd1, 0, 0, mk(1, 0, 0, 0, 1, 1));
        for (int i = 2; i <= 5; i++)
            step(1, i[2:0], 0, 0, mk(1, 0, 0, 0, 1, i[2:0]));
        // single error then recovery (7->0 also wraps)
        step(1, 3'd7, 0, 0, mk(1, 1, 1, 1, 1, 7));
        step(1, 3'd0, 0, 0, mk(1, 0, 1, 1, 2, 0));
        for (int i = 1; i <= 5; i++)
            step(1, i[2:0], 0, 0, mk(1, 0, 1, 1, 2, i[2:0]));
        // three consecutive errors drop lock; SYNC mismatches are not counted
        step(1, 3'd2, 0, 0, mk(1, 1, 1, 2, 2, 2));
        step(1, 3'd6, 0, 0, mk(1, 1, 1, 3, 2, 6));
        step(1, 3'd1, 0, 0, mk(0, 1, 1, 4, 2, 1));
        step(1, 3'd5, 0, 0, mk(0, 0, 1, 4, 2, 5));
        step(1, 3'd3, 0, 0, mk(0, 0, 1, 4, 2, 3));

        // clear, build err_cnt=2 while locked, then clear beats sample
        step(0, 3'd0, 0, 1, mk(0, 0, 0, 0, 0, 0));
        step(1, 3'd3, 0, 0, mk(0, 0, 0, 0, 0, 3));
        step(1, 3'd4, 0, 0, mk(0, 0, 0, 0, 0, 4));
        step(1, 3'd5, 0, 0, mk(1, 0, 0, 0, 0, 5));
        step(1, 3'd0, 0, 0, mk(1, 1, 1, 1, 0, 0));
        step(0, 3'd0, 0, 0, mk(1, 0, 1, 1, 0, 0));
        step(1, 3'd1, 0, 0, mk(1, 0, 1, 1, 0, 1));
        step(1, 3'd4, 0, 0, mk(1, 1, 1, 2, 0, 4));
        step(1, 3'd5, 0, 0, mk(1, 0, 1, 2, 0, 5));
        step(1, 3'd6, 0, 1, mk(0, 0, 0, 0, 0, 0));
        step(1, 3'd6, 0, 0, mk(0, 0, 0, 0, 0, 6));

        // lock going down, wrap 0->7, then direction change wraps 7->0
        step(0, 3'd0, 0, 1, mk(0, 0, 0, 0, 0, 0));
        step(1, 3'd2, 1, 0, mk(0, 0, 0, 0, 0, 2));
        step(1, 3'd1, 1, 0, mk(0, 0, 0, 0, 0, 1));
        step(1, 3'd0, 1, 0, mk(1, 0, 0, 0, 0, 0));
        step(1, 3'd7, 1, 0, mk(1, 0, 0, 0, 1, 7));
        step(1, 3'd0, 0, 0, mk(1, 0, 0, 0, 2, 0));
        step(1, 3'd5, 0, 0, mk(1, 1, 1, 1, 2, 5));

        // asynchronous reset mid-cycle
        @(negedge clk);
        sample = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst", act(), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        step(1, 3'd4, 0, 0, mk(0, 0, 0, 0, 0, 4));
        step(0, 3'd4, 0, 0, mk(0, 0, 0, 0, 0, 4));

        // LOCK_LEN=1, RELOCK_ERRS=15: 20 mismatches each followed by a match
        @(negedge clk);
        sample = 1'b0;
        sample2 = 1'b1; dir2 = 1'b0; count2 = 3'd0;
        @(negedge clk);
        count2 = 3'd1;
        cur = 3'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cur = cur + 3'd3;
            count2 = cur;
            @(negedge clk);
            cur = cur + 3'd1;
            count2 = cur;
        end
        @(negedge clk);
        sample2 = 1'b0;
        #1;
        check("saturate", mk(locked2, error2, sticky2, err_cnt2, 8'd0, 3'd0),
              mk(1, 0, 1, 15, 0, 0));
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
